hidden1_act_stream: RTL and testbench

//  Activation stage directly downstream of the Hidden1 dense layer.
//  - Captures the full vector of N_NODES signed pre-activation values in one handshake.
//  - Applies a piecewise-linear tanh approximation to each value.
//  - Streams the activations out one per cycle, with index and last flag, to the next layer's serial MAC.
//  - The capture buffer decouples Hidden1's output registers from the downstream consumer.

---
 rtl/hidden1_act_stream.sv | 153 +++++++++++++++
 tb/tb_hidden1_act_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hidden1_act_stream.sv
// Captures a Hidden1 pre-activation vector, applies a piecewise-linear tanh and streams it out.
// Optional ACT_SAT_STATS_EN adds sat_count: clamped elements accepted in the current vector.
module hidden1_act_stream #(
  parameter int N_NODES   = 128,
  parameter int DATA_W    = 9,
  parameter int FRAC_BITS = 6,
  parameter int IDX_W     = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef ACT_SAT_STATS_EN
  output logic [IDX_W:0]              sat_count,
`endif
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_NODES*DATA_W-1:0]   in_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last
);

  // state | meaning
  // IDLE  | waiting for a vector, in_ready high
  // RUN   | streaming buffered activations
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [DATA_W:0]   B_LO     = (DATA_W+1)'(1 << (FRAC_BITS-1));
  localparam logic [DATA_W:0]   B_HI     = (DATA_W+1)'(3 << (FRAC_BITS-1));
  localparam logic [DATA_W:0]   ONE      = (DATA_W+1)'(1 << FRAC_BITS);
  localparam logic [DATA_W:0]   M_HI     = (DATA_W+1)'(3 << (FRAC_BITS-2));
  localparam logic [DATA_W-1:0] ONE_W    = DATA_W'(1 << FRAC_BITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_NODES-1);

  // Unclamped magnitude; one extra bit so that |most negative| does not overflow.
  function automatic logic [DATA_W:0] act_mag(input logic [DATA_W-1:0] x);
    logic [DATA_W:0] a;
    a = x[DATA_W-1] ? ((DATA_W+1)'(0) - {x[DATA_W-1], x}) : {1'b0, x};
    if (a < B_LO)      return a;
    else if (a < B_HI) return B_LO + ((a - B_LO) >> 2);
    else               return M_HI + ((a - B_HI) >> 3);
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d, nxt_idx;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q;
  logic [DATA_W-1:0]   buf_q [N_NODES];

  logic                capture, accept, load, clamp;
  logic [DATA_W-1:0]   act_x, act_y, m_w;
  logic [DATA_W:0]     m_raw;

  assign capture = (state_q == IDLE) && in_valid && in_ready_q;
  assign accept  = out_valid_q && out_ready;
  assign nxt_idx = idx_q + IDX_W'(1);

  // Node 0 comes straight from in_vec so the first element is ready one clock after capture.
  always_comb begin
    act_x = (state_q == IDLE) ? in_vec[DATA_W-1:0] : buf_q[nxt_idx];
    m_raw = act_mag(act_x);
    clamp = m_raw > ONE;
    m_w   = clamp ? ONE_W : m_raw[DATA_W-1:0];
    act_y = act_x[DATA_W-1] ? -m_w : m_w;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    load        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (capture) begin
          state_d     = RUN;
          idx_d       = '0;
          load        = 1'b1;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b1;
          out_last_d  = (N_NODES == 1);
        end
      end
      RUN: begin
        if (accept) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            in_ready_d  = 1'b1;
          end else begin
            idx_d      = nxt_idx;
            load       = 1'b1;
            out_last_d = (nxt_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < N_NODES; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      if (load) out_data_q <= act_y;
      if (capture) begin
        for (int i = 0; i < N_NODES; i++) buf_q[i] <= in_vec[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ACT_SAT_STATS_EN
  logic              clamp_q;
  logic [IDX_W:0]    sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clamp_q <= 1'b0;
      sat_q   <= '0;
    end else begin
      if (load) clamp_q <= clamp;
      if (capture)               sat_q <= '0;
      else if (accept && clamp_q) sat_q <= sat_q + (IDX_W+1)'(1);
    end
  end

  assign sat_count = sat_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;

endmodule

// File: tb/tb_hidden1_act_stream.sv
// Directed bench for hidden1_act_stream: table of activation values plus streaming,
// backpressure, mid-stream reset and (with ACT_SAT_STATS_EN) saturation-count sequences.
module tb_hidden1_act_stream;
  localparam int N = 128;
  localparam int W = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [N*W-1:0] in_vec = '0;
  logic           in_ready, out_valid, out_last;
  logic [W-1:0]   out_data;
  logic [6:0]     out_idx;
`ifdef ACT_SAT_STATS_EN
  logic [7:0]     sat_count;
`endif

  int checks = 0;
  int errors = 0;
  int vals [N];
  int expv [N];

  typedef struct { int x; int y; } vec_t;
  vec_t tbl [19];

  always #5 clk = ~clk;

  hidden1_act_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ACT_SAT_STATS_EN
    .sat_count (sat_count),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference tanh approximation in plain integer arithmetic.
  function automatic int tb_f(input int x);
    int a, m;
    a = (x < 0) ? -x : x;
    if (a < 32)      m = a;
    else if (a < 96) m = 32 + (a - 32) / 4;
    else             m = 48 + (a - 96) / 8;
    if (m > 64) m = 64;
    return (x < 0) ? -m : m;
  endfunction

  task automatic load_vec();
    for (int i = 0; i < N; i++) in_vec[i*W +: W] = 9'(vals[i]);
  endtask

  task automatic send_vec(input string tag);
    chk($sformatf("%s in_ready before capture", tag), int'(in_ready), 1);
    load_vec();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic chk_elem(input string tag, input int i, input logic want_last);
    chk($sformatf("%s valid@%0d", tag, i), int'(out_valid), 1);
    chk($sformatf("%s idx@%0d", tag, i), int'(out_idx), i);
    chk($sformatf("%s data@%0d", tag, i), int'($signed(out_data)), expv[i]);
    chk($sformatf("%s last@%0d", tag, i), int'(out_last), int'(want_last));
  endtask

  task automatic stream(input string tag, input int stall_idx, input int stall_len, input int abort_idx);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (i == abort_idx) return;
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_len) begin
          chk_elem({tag, " stall"}, i, 1'b0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk_elem(tag, i, i == N-1);
      @(negedge clk);
    end
    chk($sformatf("%s valid after last", tag), int'(out_valid), 0);
    chk($sformatf("%s in_ready after last", tag), int'(in_ready), 1);
  endtask

  initial begin
    tbl = '{'{16, 16}, '{64, 40}, '{-64, -40}, '{128, 52}, '{255, 64}, '{-256, -64},
            '{0, 0}, '{31, 31}, '{32, 32}, '{95, 47}, '{96, 48}, '{100, 48},
            '{223, 63}, '{224, 64}, '{-1, -1}, '{-31, -31}, '{-32, -32}, '{-95, -47},
            '{-96, -48}};

    // Reset with in_valid asserted
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) in_vec[i*W +: W] = 9'($urandom);
    repeat (3) @(negedge clk);
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_data", int'(out_data), 0);
    chk("rst out_idx", int'(out_idx), 0);
    chk("rst out_last", int'(out_last), 0);
    rst_n = 1'b1;
    #1;
    chk("release in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("first edge in_ready", int'(in_ready), 1);
    chk("first edge no capture", int'(out_valid), 0);
    in_valid = 1'b0;

    // Table values, full-speed streaming
    for (int i = 0; i < N; i++) begin
      vals[i] = (i < 19) ? tbl[i].x : 0;
      expv[i] = (i < 19) ? tbl[i].y : 0;
    end
    send_vec("tbl");
    stream("tbl", -1, 0, -1);

    // Back-to-back vector, backpressure at idx 10, junk on inputs while busy
    for (int i = 0; i < N; i++) begin
      vals[i] = ((i * 37) % 512) - 256;
      expv[i] = tb_f(vals[i]);
    end
    send_vec("bp");
    in_vec   = ~in_vec;
    in_valid = 1'b1;
    stream("bp", 10, 5, -1);
    in_valid = 1'b0;

    // Reset in the middle of a vector
    for (int i = 0; i < N; i++) begin
      vals[i] = i * 3 - 192;
      expv[i] = tb_f(vals[i]);
    end
    send_vec("mid");
    stream("mid", -1, 0, 60);
    chk("mid idx before reset", int'(out_idx), 60);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst out_idx", int'(out_idx), 0);
    chk("mid rst out_last", int'(out_last), 0);
    chk("mid rst out_data", int'(out_data), 0);
    chk("mid rst in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      vals[i] = i - 64;
      expv[i] = tb_f(vals[i]);
    end
    send_vec("restart");
    stream("restart", -1, 0, -1);

`ifdef ACT_SAT_STATS_EN
    for (int i = 0; i < N; i++) begin
      vals[i] = 0;
      expv[i] = 0;
    end
    vals[5] = 255;   expv[5] = 64;
    vals[50] = -256; expv[50] = -64;
    vals[127] = 255; expv[127] = 64;
    send_vec("sat");
    stream("sat", 40, 3, -1);
    chk("sat_count after last", int'(sat_count), 3);
    for (int i = 0; i < N; i++) begin
      vals[i] = 0;
      expv[i] = 0;
    end
    send_vec("sat2");
    chk("sat_count after capture", int'(sat_count), 0);
    stream("sat2", -1, 0, -1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
